reset_pulse_gen: RTL

Source side of the reset distribution path. It generates a glitch-free, registered reset (rst_out) that drives the asynchronous reset input of a reset synchronizer in another clock domain. It waits for that domain's synchronized reset to come back as an acknowledge before releasing, and again before reporting completion. It runs on power-on and on any single-cycle software request, and flags a timeout if the far domain never responds.

---
 rtl/reset_pulse_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/reset_pulse_gen.sv
// Source side of a cross-domain reset handshake: holds rst_out high for at least
// MIN_CYCLES, waits for the far domain's synchronized reset to follow, and times out.
module reset_pulse_gen #(
   parameter int MIN_CYCLES  = 16,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic clk,
   input  logic arst,
   input  logic req,
   input  logic ack,
   output logic rst_out,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int CW = $clog2(MIN_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(MIN_CYCLES - 1);
   localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic [TW-1:0]   tcnt;
   logic [TW-1:0]   tcnt_nxt;
   logic            done_nxt;
   logic            err_nxt;

   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;

   // Holding cnt at its last value keeps the exit compare true while waiting for ack_s.
   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] val);
      if (val == CNT_LAST) begin
         return val;
      end
      return val + CW'(1);
   endfunction

   // Ack synchronizer presets high so a power-on sequence sees the far domain in reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         ack_sync <= '1;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      tcnt_nxt  = tcnt;
      done_nxt  = 1'b0;
      err_nxt   = err;
      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            tcnt_nxt = '0;
            if (req) begin
               state_nxt = ASSERT;
               err_nxt   = 1'b0;
            end
         end
         ASSERT: begin
            cnt_nxt  = sat_inc(cnt);
            tcnt_nxt = tcnt + TW'(1);
            if ((cnt == CNT_LAST) && ack_s) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
            end else if (tcnt == TCNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               tcnt_nxt  = '0;
               err_nxt   = 1'b1;
            end
         end
         RELEASE: begin
            // tcnt keeps running so the timeout spans ASSERT and RELEASE together.
            tcnt_nxt = tcnt + TW'(1);
            if (!ack_s) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               tcnt_nxt  = '0;
               done_nxt  = 1'b1;
            end else if (tcnt == TCNT_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
               tcnt_nxt  = '0;
               err_nxt   = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            tcnt_nxt  = '0;
         end
      endcase
   end

   // Outputs are registered from the next state so rst_out is glitch-free at the far domain.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= ASSERT;
         cnt     <= '0;
         tcnt    <= '0;
         rst_out <= 1'b1;
         busy    <= 1'b1;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         tcnt    <= tcnt_nxt;
         rst_out <= (state_nxt == ASSERT);
         busy    <= (state_nxt != IDLE);
         done    <= done_nxt;
         err     <= err_nxt;
      end
   end

endmodule
